button_events: RTL and testbench

- Input-side counterpart of the heartbeat LED output: conditions a raw, asynchronous, bouncing push-button into clean single-cycle events for the top level.
- Pipeline: 2-flop synchroniser, then debounce filter, then hold FSM.
- Event outputs: press, release, long-press and auto-repeat, all in the i_clk domain.

---
 rtl/btn_pkg.sv | 11 +
 rtl/debounce_filter.sv | 66 ++++++
 rtl/button_events.sv | 125 ++++++++++++
 tb/tb_button_events.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button event pipeline.
package btn_pkg;

    typedef enum logic [1:0] {IDLE, HELD, LONG} btn_state_t;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser plus stable-count debounce; o_level is 1 while pressed.
// o_change_c flags that o_level toggles at the next clock edge.
module debounce_filter
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_change_c
);

    localparam int unsigned   DW     = cnt_width(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES == 0) begin : g_bad_debounce
        $error("debounce_filter: DEBOUNCE_CYCLES must be >= 1");
    end

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic [DW-1:0] dcnt_q,  dcnt_d;
    logic          s;
    logic          change;

    assign s = sync2_q ^ ACTIVE_LOW;

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        sync1_d = i_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        dcnt_d  = '0;
        change  = 1'b0;
        if (s != level_q) begin
            if (dcnt_q == D_LAST) begin
                level_d = s;
                change  = 1'b1;
            end else begin
                dcnt_d = dcnt_q + DW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q <= ACTIVE_LOW;
            sync2_q <= ACTIVE_LOW;
            level_q <= 1'b0;
            dcnt_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            dcnt_q  <= dcnt_d;
        end
    end

    assign o_level    = level_q;
    assign o_change_c = change;

endmodule

// File: rtl/button_events.sv
// Push-button conditioner: debounced level plus press, release, long-press and
// auto-repeat single-cycle events, all registered in the i_clk domain.
module button_events
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned LONG_CYCLES     = 50_000_000,
    parameter int unsigned REPEAT_CYCLES   = 10_000_000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_repeat
);

    localparam int unsigned   HW        = cnt_width(LONG_CYCLES);
    localparam int unsigned   RW        = cnt_width(REPEAT_CYCLES);
    localparam logic [HW-1:0] H_LAST    = HW'(LONG_CYCLES - 1);
    localparam logic [RW-1:0] R_LAST    = RW'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);
    localparam bit            REPEAT_EN = (REPEAT_CYCLES != 0);

    if (LONG_CYCLES == 0) begin : g_bad_long
        $error("button_events: LONG_CYCLES must be >= 1");
    end

    btn_state_t    state_q, state_d;
    logic [HW-1:0] hcnt_q,  hcnt_d;
    logic [RW-1:0] rcnt_q,  rcnt_d;
    logic          press_q, press_d;
    logic          rel_q,   rel_d;
    logic          long_q,  long_d;
    logic          rpt_q,   rpt_d;
    logic          level;
    logic          change_c;

    debounce_filter #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_filter (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_raw     (i_btn),
        .o_level   (level),
        .o_change_c(change_c)
    );

    // Events are decided one cycle early so they align with the o_level edge;
    // a pending release outranks long/repeat on the same cycle.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        rcnt_d  = rcnt_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        long_d  = 1'b0;
        rpt_d   = 1'b0;
        if (change_c && !level) begin
            press_d = 1'b1;
            state_d = HELD;
            hcnt_d  = '0;
            rcnt_d  = '0;
        end else if (change_c && level) begin
            rel_d   = 1'b1;
            state_d = IDLE;
            hcnt_d  = '0;
            rcnt_d  = '0;
        end else begin
            case (state_q)
                HELD: begin
                    if (hcnt_q == H_LAST) begin
                        long_d  = 1'b1;
                        state_d = LONG;
                        hcnt_d  = '0;
                        rcnt_d  = '0;
                    end else begin
                        hcnt_d = hcnt_q + HW'(1);
                    end
                end
                LONG: begin
                    if (REPEAT_EN) begin
                        if (rcnt_q == R_LAST) begin
                            rpt_d  = 1'b1;
                            rcnt_d = '0;
                        end else begin
                            rcnt_d = rcnt_q + RW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            rcnt_q  <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            long_q  <= 1'b0;
            rpt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            rcnt_q  <= rcnt_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            long_q  <= long_d;
            rpt_q   <= rpt_d;
        end
    end

    assign o_level   = level;
    assign o_press   = press_q;
    assign o_release = rel_q;
    assign o_long    = long_q;
    assign o_repeat  = rpt_q;

endmodule

// File: tb/tb_button_events.sv
// Bench for button_events: three instances (base, repeat disabled, active-low pin)
// checked every cycle against an event-time reference model plus directed vectors.
module tb_button_events;

    localparam int D    = 4;
    localparam int L    = 20;
    localparam int NDUT = 3;

    logic clk;
    logic rst_r[NDUT];
    logic btn_r[NDUT];
    logic lvl_w[NDUT];
    logic prs_w[NDUT];
    logic rel_w[NDUT];
    logic lng_w[NDUT];
    logic rpt_w[NDUT];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    button_events #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(5), .ACTIVE_LOW(1'b0)) dut_a (
        .i_clk(clk), .i_rst(rst_r[0]), .i_btn(btn_r[0]), .o_level(lvl_w[0]), .o_press(prs_w[0]),
        .o_release(rel_w[0]), .o_long(lng_w[0]), .o_repeat(rpt_w[0]));
    button_events #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(0), .ACTIVE_LOW(1'b0)) dut_b (
        .i_clk(clk), .i_rst(rst_r[1]), .i_btn(btn_r[1]), .o_level(lvl_w[1]), .o_press(prs_w[1]),
        .o_release(rel_w[1]), .o_long(lng_w[1]), .o_repeat(rpt_w[1]));
    button_events #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(5), .ACTIVE_LOW(1'b1)) dut_c (
        .i_clk(clk), .i_rst(rst_r[2]), .i_btn(btn_r[2]), .o_level(lvl_w[2]), .o_press(prs_w[2]),
        .o_release(rel_w[2]), .o_long(lng_w[2]), .o_repeat(rpt_w[2]));

    int   n;
    int   vectors;
    int   miscompares;
    logic want_rst[NDUT];
    logic want_btn[NDUT];

    // Reference model: pressed-pin delay line, stable-run length of s, event times.
    logic m_pp0[NDUT], m_pp1[NDUT], m_level[NDUT];
    logic m_press[NDUT], m_rel[NDUT], m_long[NDUT], m_rpt[NDUT];
    int   m_streak[NDUT], m_t[NDUT];

    typedef struct {
        int id;
        int hold;
        int e_long;
        int e_nrep;
        int e_first;
        int e_last;
        int e_rel;
    } vec_t;

    vec_t vecs[7];

    function automatic int p_rep(input int i);
        return (i == 1) ? 0 : 5;
    endfunction

    function automatic logic p_al(input int i);
        return (i == 2);
    endfunction

    task automatic chk(input string nm, input int i, input logic got, input logic exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d cycle %0d: got %b want %b", nm, i, n, got, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int i, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s dut%0d cycle %0d: got %0d want %0d", nm, i, n, got, exp);
        end
    endtask

    task automatic model_step(input int i, input logic pin, input logic rst);
        logic s_now;
        logic nl;
        int   age;
        if (rst) begin
            m_pp0[i] = 1'b0; m_pp1[i] = 1'b0; m_streak[i] = 1; m_level[i] = 1'b0;
            m_press[i] = 1'b0; m_rel[i] = 1'b0; m_long[i] = 1'b0; m_rpt[i] = 1'b0;
            m_t[i] = -1;
            return;
        end
        s_now = m_pp1[i];
        nl    = m_level[i];
        if (s_now != m_level[i] && m_streak[i] >= D) nl = s_now;
        m_pp1[i] = m_pp0[i];
        m_pp0[i] = pin ^ p_al(i);
        if (m_pp1[i] == s_now) begin
            if (m_streak[i] < 1000000) m_streak[i]++;
        end else begin
            m_streak[i] = 1;
        end
        m_press[i] = nl & ~m_level[i];
        m_rel[i]   = ~nl & m_level[i];
        if (m_press[i]) m_t[i] = n + 1;
        age        = n + 1 - m_t[i];
        m_long[i]  = nl && (age == L);
        m_rpt[i]   = nl && (p_rep(i) > 0) && (age > L) && (((age - L) % p_rep(i)) == 0);
        m_level[i] = nl;
    endtask

    // Apply this cycle's inputs, then check the next cycle's outputs at the falling edge.
    task automatic cycle();
        for (int i = 0; i < NDUT; i++) begin
            rst_r[i] = want_rst[i];
            btn_r[i] = want_btn[i];
            model_step(i, want_btn[i], want_rst[i]);
        end
        @(negedge clk);
        n++;
        for (int i = 0; i < NDUT; i++) begin
            chk("level",   i, lvl_w[i], m_level[i]);
            chk("press",   i, prs_w[i], m_press[i]);
            chk("release", i, rel_w[i], m_rel[i]);
            chk("long",    i, lng_w[i], m_long[i]);
            chk("repeat",  i, rpt_w[i], m_rpt[i]);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int i, cp, t, long_off, nrep, first_rep, last_rep, rel_off;
        i  = v.id;
        cp = n;
        t  = -1;
        want_btn[i] = ~p_al(i);
        for (int k = 0; k < 20 && t < 0; k++) begin
            cycle();
            if (prs_w[i]) t = n;
        end
        chk_int("vec_press_latency", i, (t < 0) ? -1 : t - cp, 6);
        if (t < 0) begin
            want_btn[i] = p_al(i);
            repeat (20) cycle();
            return;
        end
        long_off = -1; nrep = 0; first_rep = -1; last_rep = -1; rel_off = -1;
        while (n < t + v.hold + 10) begin
            if (n == t + v.hold - 6) want_btn[i] = p_al(i);
            cycle();
            if (lng_w[i] && long_off < 0) long_off = n - t;
            if (rpt_w[i]) begin
                nrep++;
                if (first_rep < 0) first_rep = n - t;
                last_rep = n - t;
            end
            if (rel_w[i] && rel_off < 0) rel_off = n - t;
        end
        chk_int("vec_long_offset",    i, long_off,  v.e_long);
        chk_int("vec_repeat_count",   i, nrep,      v.e_nrep);
        chk_int("vec_first_repeat",   i, first_rep, v.e_first);
        chk_int("vec_last_repeat",    i, last_rep,  v.e_last);
        chk_int("vec_release_offset", i, rel_off,   v.e_rel);
        repeat (5) cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", n);
        $fatal(1, "watchdog");
    end

    initial begin
        int e, tp, hi, np, nr, t, rd, cp, cnt;
        int left[NDUT];
        n = 0; vectors = 0; miscompares = 0;
        vecs[0] = '{0, 10, -1, 0, -1, -1, 10};
        vecs[1] = '{0, 42, 20, 4, 25, 40, 42};
        vecs[2] = '{0, 20, -1, 0, -1, -1, 20};
        vecs[3] = '{0, 21, 20, 0, -1, -1, 21};
        vecs[4] = '{0, 25, 20, 0, -1, -1, 25};
        vecs[5] = '{1, 60, 20, 0, -1, -1, 60};
        vecs[6] = '{2, 31, 20, 2, 25, 30, 31};

        // Reset with idle pins, then a quiet stretch.
        for (int i = 0; i < NDUT; i++) begin
            want_rst[i] = 1'b1;
            want_btn[i] = p_al(i);
        end
        repeat (5) cycle();
        for (int i = 0; i < NDUT; i++) begin
            chk("reset_level", i, lvl_w[i], 1'b0);
            chk("reset_press", i, prs_w[i], 1'b0);
            want_rst[i] = 1'b0;
        end
        for (int i = 0; i < NDUT; i++) left[i] = 0;
        for (int k = 0; k < 50; k++) begin
            cycle();
            for (int i = 0; i < NDUT; i++)
                left[i] += int'(lvl_w[i] | prs_w[i] | rel_w[i] | lng_w[i] | rpt_w[i]);
        end
        for (int i = 0; i < NDUT; i++) chk_int("idle_activity", i, left[i], 0);

        // Bouncing pin: toggles every 2 cycles, then settles high.
        e = n + 18; hi = 0; np = 0; nr = 0; tp = -1;
        for (int k = 0; k < 20; k++) begin
            want_btn[0] = (((k / 2) % 2) == 1);
            cycle();
            if (lvl_w[0]) hi++;
            if (prs_w[0]) np++;
            if (rel_w[0]) nr++;
        end
        want_btn[0] = 1'b1;
        while (n < e + 10) begin
            cycle();
            if (prs_w[0]) begin
                np++;
                if (tp < 0) tp = n;
            end
            if (rel_w[0]) nr++;
        end
        chk_int("bounce_level_high",   0, hi, 0);
        chk_int("bounce_press_latency", 0, (tp < 0) ? -1 : tp - e, 6);
        chk_int("bounce_press_count",  0, np, 1);
        chk_int("bounce_release_count", 0, nr, 0);
        want_btn[0] = 1'b0;
        repeat (25) cycle();

        for (int v = 0; v < 7; v++) run_vec(vecs[v]);

        // Active-low pin, reset pulsed while in the long-press state.
        cp = n; t = -1;
        want_btn[2] = 1'b0;
        for (int k = 0; k < 20 && t < 0; k++) begin
            cycle();
            if (prs_w[2]) t = n;
        end
        chk_int("al_press_latency", 2, (t < 0) ? -1 : t - cp, 6);
        if (t < 0) t = n;
        while (n < t + 22) cycle();
        want_rst[2] = 1'b1;
        cycle();
        chk("rst_level",   2, lvl_w[2], 1'b0);
        chk("rst_press",   2, prs_w[2], 1'b0);
        chk("rst_release", 2, rel_w[2], 1'b0);
        chk("rst_long",    2, lng_w[2], 1'b0);
        chk("rst_repeat",  2, rpt_w[2], 1'b0);
        want_rst[2] = 1'b0;
        rd = n; tp = -1; nr = 0;
        for (int k = 0; k < 20 && tp < 0; k++) begin
            cycle();
            if (prs_w[2]) tp = n;
            if (rel_w[2]) nr++;
        end
        chk_int("post_reset_press_latency", 2, (tp < 0) ? -1 : tp - rd, 6);
        chk_int("post_reset_release_count", 2, nr, 0);
        want_btn[2] = 1'b1;
        repeat (30) cycle();

        // Random run lengths (bounce-sized and hold-sized) with rare resets.
        for (int i = 0; i < NDUT; i++) left[i] = 0;
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < NDUT; i++) begin
                if (left[i] == 0) begin
                    want_btn[i] = 1'($urandom_range(0, 1));
                    cnt = ($urandom_range(0, 3) == 0) ? 1 : 4;
                    left[i] = (cnt == 1) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 45));
                end
                left[i]--;
                want_rst[i] = ($urandom_range(0, 199) == 0);
            end
            cycle();
        end
        for (int i = 0; i < NDUT; i++) begin
            want_rst[i] = 1'b0;
            want_btn[i] = p_al(i);
        end
        repeat (40) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
